// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID-stage control unit: instruction classes,
// opcodes, ALU command codes, condition codes and status flag positions.
package ctrl_pkg;

    // Instruction class carried in the mode field
    typedef enum logic [1:0] {
        MODE_ARITH  = 2'b00,
        MODE_MEM    = 2'b01,
        MODE_BRANCH = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    // Data-processing opcodes
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // Load/store share one opcode; the S bit picks the direction
    localparam logic [3:0] OP_LDST = 4'b0100;

    // ALU command codes (zero-extended to the exe_cmd width)
    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;

    // Bit positions inside the {N,Z,C,V} status vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Control word produced by the decoder and held in the ID/EX register
    typedef struct packed {
        logic [3:0] cmd;
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic       b;
        logic       s;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode_pipe_cond_check.sv
// Evaluates the condition field of an instruction against the NZCV flags.
module cond_check
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] status,
    output logic       pass
);

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;

    assign n_flag = status[FLAG_N];
    assign z_flag = status[FLAG_Z];
    assign c_flag = status[FLAG_C];
    assign v_flag = status[FLAG_V];

    // Look up the pass/fail result for each condition; 1110/1111 always pass
    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z_flag;
            COND_NE: pass = !z_flag;
            COND_CS: pass = c_flag;
            COND_CC: pass = !c_flag;
            COND_MI: pass = n_flag;
            COND_PL: pass = !n_flag;
            COND_VS: pass = v_flag;
            COND_VC: pass = !v_flag;
            COND_HI: pass = c_flag && !z_flag;
            COND_LS: pass = !c_flag || z_flag;
            COND_GE: pass = (n_flag == v_flag);
            COND_LT: pass = (n_flag != v_flag);
            COND_GT: pass = !z_flag && (n_flag == v_flag);
            COND_LE: pass = z_flag || (n_flag != v_flag);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ID-stage control unit: decodes the instruction, applies the condition
// check and registers the control word into the ID/EX pipeline register,
// with freeze, flush, hazard bubbles and a branch-shadow squash counter.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int EXEC_CMD_W = 4,
    parameter int REG_ADDR_W = 4,
    parameter int BR_SHADOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    input  logic [3:0]            cond,
    input  logic [1:0]            mode,
    input  logic [3:0]            op_code,
    input  logic                  s_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [3:0]            status,
    input  logic                  freeze,
    input  logic                  hazard,
    input  logic                  flush,
    output logic [EXEC_CMD_W-1:0] exe_cmd,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_en,
    output logic                  b,
    output logic                  s_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic                  valid_out,
    output logic                  squash_active
);

    localparam int CNT_W = 3;

    logic                  cond_pass;
    ctrl_word_t            dec_word;
    ctrl_word_t            ctrl_d, ctrl_q;
    logic [REG_ADDR_W-1:0] dest_d, dest_q;
    logic                  valid_d, valid_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;

    cond_check u_cond_check (
        .cond   (cond),
        .status (status),
        .pass   (cond_pass)
    );

    // Translate mode/opcode/S into a control word; unknown encodings give a NOP
    always_comb begin
        dec_word = '0;
        case (mode_e'(mode))
            MODE_ARITH: begin
                dec_word.s     = s_in;
                dec_word.wb_en = 1'b1;
                case (op_code)
                    OP_MOV:  dec_word.cmd = CMD_MOV;
                    OP_MVN:  dec_word.cmd = CMD_MVN;
                    OP_ADD:  dec_word.cmd = CMD_ADD;
                    OP_ADC:  dec_word.cmd = CMD_ADC;
                    OP_SUB:  dec_word.cmd = CMD_SUB;
                    OP_SBC:  dec_word.cmd = CMD_SBC;
                    OP_AND:  dec_word.cmd = CMD_AND;
                    OP_ORR:  dec_word.cmd = CMD_ORR;
                    OP_EOR:  dec_word.cmd = CMD_EOR;
                    OP_CMP: begin
                        dec_word.cmd   = CMD_SUB;
                        dec_word.wb_en = 1'b0;
                        dec_word.s     = 1'b1;
                    end
                    OP_TST: begin
                        dec_word.cmd   = CMD_AND;
                        dec_word.wb_en = 1'b0;
                        dec_word.s     = 1'b1;
                    end
                    default: dec_word = '0;
                endcase
            end
            MODE_MEM: begin
                if (op_code == OP_LDST) begin
                    dec_word.cmd       = CMD_ADD;
                    dec_word.mem_read  = s_in;
                    dec_word.wb_en     = s_in;
                    dec_word.mem_write = !s_in;
                end
            end
            MODE_BRANCH: dec_word.b = 1'b1;
            default:     dec_word = '0;
        endcase
    end

    // Choose the next ID/EX contents: freeze, flush, shadow squash, hazard, issue
    always_comb begin
        ctrl_d  = ctrl_q;
        dest_d  = dest_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (!freeze) begin
            ctrl_d  = '0;
            dest_d  = '0;
            valid_d = 1'b0;
            if (flush) begin
                cnt_d = '0;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (!hazard && instr_valid && cond_pass) begin
                ctrl_d  = dec_word;
                dest_d  = dest_in;
                valid_d = 1'b1;
                if (dec_word.b) begin
                    cnt_d = CNT_W'(BR_SHADOW);
                end
            end
        end
    end

    // ID/EX pipeline register and shadow counter with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q  <= '0;
            dest_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            dest_q  <= dest_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign exe_cmd       = EXEC_CMD_W'(ctrl_q.cmd);
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign wb_en         = ctrl_q.wb_en;
    assign b             = ctrl_q.b;
    assign s_out         = ctrl_q.s;
    assign dest_out      = dest_q;
    assign valid_out     = valid_q;
    assign squash_active = (cnt_q != '0);

endmodule
